cdb_issue_scheduler: RTL and testbench

Issue-stage scheduler for the out-of-order core. It arbitrates among the four issue queues (INT, LD_ST, MULT, DIV) and grants at most one issue per cycle. It keeps a per-cycle reservation of the common data bus (CDB) so that no two functional units write back in the same cycle. Each cycle it reports which unit owns the CDB, which drives the CDB result mux in front of `cdb_bfm`.

---
 rtl/cdb_issue_scheduler.sv | 122 ++++++++++++
 tb/tb_cdb_issue_scheduler.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/cdb_issue_scheduler.sv
//------------------------------------------------------------------------------
// Module   : cdb_issue_scheduler
// Brief    : Issue arbiter for INT/LD_ST/MULT/DIV with CDB write-back slot reservation.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cdb_issue_scheduler #(
  parameter int INT_LAT  = 1,
  parameter int LDST_LAT = 2,
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 8,
  parameter int DEPTH    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_flush,
  input  logic       i_int_issue_rdy,
  input  logic       i_ldst_issue_rdy,
  input  logic       i_mult_issue_rdy,
  input  logic       i_div_issue_rdy,
  output logic [3:0] o_issue_grant,
  output logic [1:0] o_cdb_sel,
  output logic       o_cdb_sel_valid,
  output logic       o_div_busy
);

  localparam int c_dcw = $clog2(DIV_LAT + 1);

  logic [DEPTH:1]   r_slot_v;
  logic [1:0]       r_slot_u [1:DEPTH];
  logic [c_dcw-1:0] r_div_cnt;
  logic             r_rr_ldst;

  logic [3:0] w_rdy;
  logic [3:0] w_free;
  logic [3:0] w_elig;
  logic [3:0] w_grant;

  assign w_rdy = {i_div_issue_rdy, i_mult_issue_rdy, i_ldst_issue_rdy, i_int_issue_rdy};

  // A unit may land in slot[L] only if nothing is about to shift into it.
  for (genvar g = 0; g < 4; g++) begin : g_unit
    localparam int c_l = (g == 0) ? INT_LAT  :
                         (g == 1) ? LDST_LAT :
                         (g == 2) ? MULT_LAT : DIV_LAT;
    if (c_l < 1 || c_l > DEPTH) begin : g_bad_lat
      $error("cdb_issue_scheduler: unit latency outside 1..DEPTH");
    end
    if (c_l >= DEPTH) begin : g_top
      assign w_free[g] = 1'b1;
    end else begin : g_chk
      assign w_free[g] = ~r_slot_v[c_l+1];
    end
  end

  assign w_elig = w_rdy & w_free & {(r_div_cnt == '0), 3'b111} & {4{~i_flush & rst_n}};

  always_comb begin
    w_grant = 4'b0000;
    if (w_elig[3])                 w_grant = 4'b1000;
    else if (w_elig[2])            w_grant = 4'b0100;
    else if (w_elig[0] && w_elig[1]) w_grant = r_rr_ldst ? 4'b0010 : 4'b0001;
    else if (w_elig[0])            w_grant = 4'b0001;
    else if (w_elig[1])            w_grant = 4'b0010;
  end

  assign o_issue_grant   = w_grant;
  assign o_cdb_sel       = r_slot_u[1];
  assign o_cdb_sel_valid = r_slot_v[1];
  assign o_div_busy      = (r_div_cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot_v  <= '0;
      for (int i = 1; i <= DEPTH; i++) r_slot_u[i] <= 2'd0;
      r_div_cnt <= '0;
      r_rr_ldst <= 1'b0;
    end else if (i_flush) begin
      r_slot_v  <= '0;
      for (int i = 1; i <= DEPTH; i++) r_slot_u[i] <= 2'd0;
      r_div_cnt <= '0;
      r_rr_ldst <= 1'b0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        r_slot_v[i] <= r_slot_v[i+1];
        r_slot_u[i] <= r_slot_u[i+1];
      end
      r_slot_v[DEPTH] <= 1'b0;
      r_slot_u[DEPTH] <= 2'd0;

      // Later assignments override the shifted-in (empty) value.
      if (w_grant[0]) begin
        r_slot_v[INT_LAT] <= 1'b1;
        r_slot_u[INT_LAT] <= 2'd0;
      end
      if (w_grant[1]) begin
        r_slot_v[LDST_LAT] <= 1'b1;
        r_slot_u[LDST_LAT] <= 2'd1;
      end
      if (w_grant[2]) begin
        r_slot_v[MULT_LAT] <= 1'b1;
        r_slot_u[MULT_LAT] <= 2'd2;
      end
      if (w_grant[3]) begin
        r_slot_v[DIV_LAT] <= 1'b1;
        r_slot_u[DIV_LAT] <= 2'd3;
      end

      if (w_grant[3])
        r_div_cnt <= c_dcw'(DIV_LAT - 1);
      else if (r_div_cnt != '0)
        r_div_cnt <= r_div_cnt - c_dcw'(1);

      if (w_elig[0] && w_elig[1] && (w_grant[0] || w_grant[1]))
        r_rr_ldst <= w_grant[0];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cdb_issue_scheduler.sv
//------------------------------------------------------------------------------
// Module   : tb_cdb_issue_scheduler
// Brief    : Directed self-checking bench with CDB write-back scoreboard.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_cdb_issue_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       int_rdy, ldst_rdy, mult_rdy, div_rdy;
  logic [3:0] grant;
  logic [1:0] cdb_sel;
  logic       cdb_valid;
  logic       div_busy;

  cdb_issue_scheduler dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_flush          (flush),
    .i_int_issue_rdy  (int_rdy),
    .i_ldst_issue_rdy (ldst_rdy),
    .i_mult_issue_rdy (mult_rdy),
    .i_div_issue_rdy  (div_rdy),
    .o_issue_grant    (grant),
    .o_cdb_sel        (cdb_sel),
    .o_cdb_sel_valid  (cdb_valid),
    .o_div_busy       (div_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [1:0] unit;
  } sb_t;

  localparam int LAT [4] = '{1, 2, 4, 8};

  sb_t sb[$];
  int  nvec   = 0;
  int  nerr   = 0;
  int  cyc    = 0;
  int  div_lo = -1;
  int  div_hi = -2;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Drive one cycle, check grant/CDB/div_busy mid-cycle, then book expected write-backs.
  task automatic step(input logic [3:0] rdy, input logic fl, input logic [3:0] eg);
    logic [2:0] ecdb;
    {div_rdy, mult_rdy, ldst_rdy, int_rdy} = rdy;
    flush = fl;
    @(negedge clk);
    check("grant", 8'(grant), 8'(eg));
    ecdb = 3'b000;
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].due == cyc) begin
        ecdb = {1'b1, sb[i].unit};
        sb.delete(i);
        break;
      end
    end
    check("cdb", 8'({cdb_valid, cdb_valid ? cdb_sel : 2'b00}), 8'(ecdb));
    check("div_busy", 8'(div_busy), 8'((cyc >= div_lo) && (cyc <= div_hi)));
    if (fl) begin
      sb.delete();
      if (div_hi > cyc) div_hi = cyc;
    end else begin
      for (int u = 0; u < 4; u++) begin
        if (eg[u]) begin
          sb.push_back('{cyc + LAT[u], 2'(u)});
          if (u == 3) begin
            div_lo = cyc + 1;
            div_hi = cyc + LAT[3] - 1;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    {div_rdy, mult_rdy, ldst_rdy, int_rdy} = 4'b1111;
    repeat (2) @(negedge clk);
    check("rst_grant", 8'(grant), 8'h00);
    check("rst_valid", 8'(cdb_valid), 8'h00);
    check("rst_sel", 8'(cdb_sel), 8'h00);
    check("rst_busy", 8'(div_busy), 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;

    // Reset release with everything ready: DIV first, then MULT, then flush with ready held.
    step(4'b1111, 1'b0, 4'b1000);
    step(4'b1111, 1'b0, 4'b0100);
    step(4'b1111, 1'b0, 4'b0100);
    step(4'b1111, 1'b1, 4'b0000);

    // Latency: lone INT then lone MULT.
    repeat (3) step(4'b0000, 1'b0, 4'b0000);
    step(4'b0001, 1'b0, 4'b0001);
    repeat (4) step(4'b0000, 1'b0, 4'b0000);
    step(4'b0100, 1'b0, 4'b0100);
    repeat (5) step(4'b0000, 1'b0, 4'b0000);

    // Collision against an in-flight MULT.
    step(4'b0100, 1'b0, 4'b0100);
    step(4'b0011, 1'b0, 4'b0001);
    step(4'b0011, 1'b0, 4'b0001);
    step(4'b0011, 1'b0, 4'b0010);
    step(4'b0011, 1'b0, 4'b0010);
    repeat (4) step(4'b0000, 1'b0, 4'b0000);
    step(4'b0000, 1'b1, 4'b0000);

    // Round-robin with both eligible, then continuous requests.
    step(4'b0011, 1'b0, 4'b0001);
    step(4'b0000, 1'b0, 4'b0000);
    step(4'b0000, 1'b0, 4'b0000);
    step(4'b0011, 1'b0, 4'b0010);
    step(4'b0000, 1'b0, 4'b0000);
    step(4'b0000, 1'b0, 4'b0000);
    step(4'b0011, 1'b0, 4'b0001);
    step(4'b0011, 1'b0, 4'b0010);
    step(4'b0011, 1'b0, 4'b0010);
    step(4'b0011, 1'b0, 4'b0010);
    step(4'b0001, 1'b0, 4'b0000);
    step(4'b0001, 1'b0, 4'b0001);
    repeat (3) step(4'b0000, 1'b0, 4'b0000);
    step(4'b0000, 1'b1, 4'b0000);

    // Divider occupancy with ready held high.
    for (int t = 0; t < 17; t++)
      step(4'b1000, 1'b0, ((t % 8) == 0) ? 4'b1000 : 4'b0000);
    step(4'b0000, 1'b1, 4'b0000);

    // Flush discards MULT and DIV in flight; DIV re-issues immediately.
    step(4'b0100, 1'b0, 4'b0100);
    step(4'b1000, 1'b0, 4'b1000);
    step(4'b0000, 1'b1, 4'b0000);
    step(4'b1000, 1'b0, 4'b1000);
    repeat (3) step(4'b0000, 1'b0, 4'b0000);

    // Asynchronous reset while the divider is busy.
    {div_rdy, mult_rdy, ldst_rdy, int_rdy} = 4'b1111;
    rst_n = 1'b0;
    #1;
    check("arst_grant", 8'(grant), 8'h00);
    check("arst_valid", 8'(cdb_valid), 8'h00);
    check("arst_busy", 8'(div_busy), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire
